// File: rtl/jesd204b_pkg.sv
// Shared JESD204B link-layer constants, link state encoding and the lane octet payload.
package jesd204b_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_7 = 8'hFC;

  localparam int unsigned ILAS_CFG_LEN = 14;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } link_state_e;

  // One octet headed for the 8B10B encoder plus its control-character flag.
  typedef struct packed {
    logic       k;
    logic [7:0] octet;
  } lane_octet_t;

  function automatic lane_octet_t kchar(input logic [7:0] c);
    lane_octet_t o;
    o.k     = 1'b1;
    o.octet = c;
    return o;
  endfunction

  function automatic lane_octet_t dchar(input logic [7:0] d);
    lane_octet_t o;
    o.k     = 1'b0;
    o.octet = d;
    return o;
  endfunction

endpackage

// File: rtl/jesd204b_tx_link_ctrl_if.sv
// Lane-side signals of the TX link controller: receiver SYNC~, scrambler input, encoder output.
interface jesd204b_tx_link_ctrl_if;
  import jesd204b_pkg::*;

  logic                        sync_n;
  logic [7:0]                  data_in;
  logic [8*ILAS_CFG_LEN-1:0]   cfg_in;
  logic [7:0]                  data_out;
  logic                        k_out;
  logic                        data_en;
  logic                        link_up;

  modport master (
    input  sync_n, data_in, cfg_in,
    output data_out, k_out, data_en, link_up
  );

  modport slave (
    output sync_n, data_in, cfg_in,
    input  data_out, k_out, data_en, link_up
  );

endinterface

// File: rtl/jesd204b_lmfc.sv
// Local multiframe clock: free-running octet position within the multiframe plus frame/multiframe ends.
module jesd204b_lmfc #(
  parameter int unsigned F = 4,
  parameter int unsigned K = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [$clog2(F*K)-1:0]    pos,
  output logic                      frame_end,
  output logic                      mf_end
);

  localparam int unsigned FK    = F * K;
  localparam int unsigned POS_W = $clog2(FK);
  localparam int unsigned FW    = (F > 1) ? $clog2(F) : 1;

  // Octet index within the current frame; avoids a modulo on pos.
  logic [FW-1:0] fpos;

  always_ff @(posedge clk) begin
    if (reset) begin
      pos  <= '0;
      fpos <= '0;
    end else begin
      pos  <= mf_end ? '0 : pos + POS_W'(1);
      fpos <= frame_end ? '0 : fpos + FW'(1);
    end
  end

  assign frame_end = (fpos == FW'(F - 1));
  assign mf_end    = (pos == POS_W'(FK - 1));

endmodule

// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B TX data-link control for one lane: CGS, ILAS and scrambled data with /A/ /F/ insertion.
module jesd204b_tx_link_ctrl
  import jesd204b_pkg::*;
#(
  parameter int unsigned F            = 4,
  parameter int unsigned K            = 32,
  parameter int unsigned ILAS_MF      = 4,
  parameter int unsigned SYNC_LOW_MIN = 4,
  parameter bit          SCRAMBLED    = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  jesd204b_tx_link_ctrl_if.master lane
);

  localparam int unsigned FK    = F * K;
  localparam int unsigned POS_W = $clog2(FK);
  localparam int unsigned MF_W  = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int unsigned LC_W  = $clog2(SYNC_LOW_MIN + 1);

  logic [POS_W-1:0] pos;
  logic             frame_end;
  logic             mf_end;

  link_state_e      state;
  logic [MF_W-1:0]  mf;
  logic [7:0]       ramp;
  logic [LC_W-1:0]  low_cnt;
  logic             sync_r;
  lane_octet_t      out_q;
  logic             link_up_q;

  logic [7:0]       cfg_oct [16];
  logic [3:0]       cfg_idx;
  lane_octet_t      ilas_oct_c;
  lane_octet_t      data_oct_c;
  logic             ramp_inc_c;
  logic             mf_last_c;
  logic             resync_c;
  logic [LC_W-1:0]  low_cnt_nxt_c;

  jesd204b_lmfc #(.F(F), .K(K)) u_lmfc (
    .clk       (clk),
    .reset     (reset),
    .pos       (pos),
    .frame_end (frame_end),
    .mf_end    (mf_end)
  );

  // Configuration octets as an array; the two spare slots keep a 4-bit index in range.
  always_comb begin
    cfg_oct[14] = 8'h00;
    cfg_oct[15] = 8'h00;
    for (int j = 0; j < int'(ILAS_CFG_LEN); j++) begin
      cfg_oct[j] = lane.cfg_in[8*j +: 8];
    end
  end

  // ILAS octet for the current position; also used for the entry octet straight out of CGS.
  always_comb begin
    ramp_inc_c = 1'b0;
    cfg_idx    = 4'(pos - POS_W'(2));
    if (pos == '0) begin
      ilas_oct_c = kchar(K28_0);
    end else if (mf_end) begin
      ilas_oct_c = kchar(K28_3);
    end else if (mf == MF_W'(1) && pos == POS_W'(1)) begin
      ilas_oct_c = kchar(K28_4);
    end else if (mf == MF_W'(1) && pos >= POS_W'(2) && pos <= POS_W'(15)) begin
      ilas_oct_c = dchar(cfg_oct[cfg_idx]);
    end else begin
      ilas_oct_c = dchar(ramp);
      ramp_inc_c = 1'b1;
    end
  end

  // User data with alignment/frame character replacement.
  always_comb begin
    data_oct_c = dchar(lane.data_in);
    if (SCRAMBLED) begin
      if (mf_end && lane.data_in == K28_3) begin
        data_oct_c = kchar(K28_3);
      end else if (frame_end && !mf_end && lane.data_in == K28_7) begin
        data_oct_c = kchar(K28_7);
      end
    end
  end

  always_comb begin
    mf_last_c = (mf == MF_W'(ILAS_MF - 1));
    if (sync_r) begin
      low_cnt_nxt_c = '0;
    end else if (low_cnt == LC_W'(SYNC_LOW_MIN)) begin
      low_cnt_nxt_c = low_cnt;
    end else begin
      low_cnt_nxt_c = low_cnt + LC_W'(1);
    end
    resync_c = !sync_r && (low_cnt == LC_W'(SYNC_LOW_MIN - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CGS;
      mf        <= '0;
      ramp      <= '0;
      low_cnt   <= '0;
      sync_r    <= 1'b0;
      out_q     <= '0;
      link_up_q <= 1'b0;
    end else begin
      sync_r    <= lane.sync_n;
      link_up_q <= (state == DATA);
      case (state)
        CGS: begin
          mf      <= '0;
          ramp    <= '0;
          low_cnt <= '0;
          // A high SYNC~ at the multiframe boundary makes this very octet the first /R/.
          if (sync_r && pos == '0) begin
            state <= ILAS;
            out_q <= ilas_oct_c;
          end else begin
            out_q <= kchar(K28_5);
          end
        end
        ILAS: begin
          out_q   <= ilas_oct_c;
          low_cnt <= low_cnt_nxt_c;
          if (ramp_inc_c) ramp <= ramp + 8'd1;
          if (mf_end) mf <= mf_last_c ? '0 : mf + MF_W'(1);
          if (resync_c) begin
            state <= CGS;
          end else if (mf_end && mf_last_c) begin
            state <= DATA;
          end
        end
        DATA: begin
          out_q   <= data_oct_c;
          low_cnt <= low_cnt_nxt_c;
          if (resync_c) state <= CGS;
        end
        default: state <= CGS;
      endcase
    end
  end

  assign lane.data_out = out_q.octet;
  assign lane.k_out    = out_q.k;
  assign lane.link_up  = link_up_q;
  assign lane.data_en  = (state == DATA);

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Self-checking bench: behavioural lane model, vector table for replacement, corner-case sequences.
module tb_jesd204b_tx_link_ctrl;
  import jesd204b_pkg::*;

  localparam int F       = 4;
  localparam int K       = 32;
  localparam int FK      = F * K;
  localparam int ILAS_MF = 4;
  localparam int SLM     = 4;
  localparam bit SCR     = 1'b1;
  localparam int ILAS_N  = ILAS_MF * FK;

  logic clk = 1'b0;
  logic reset = 1'b1;

  jesd204b_tx_link_ctrl_if lane_if();

  jesd204b_tx_link_ctrl #(
    .F(F), .K(K), .ILAS_MF(ILAS_MF), .SYNC_LOW_MIN(SLM), .SCRAMBLED(SCR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .lane  (lane_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: 0 = sync, 1 = alignment sequence, 2 = user data
  int   m_state, m_cyc, m_low, m_idx;
  logic m_sync_r;
  logic [7:0] cfg [ILAS_CFG_LEN];
  logic [7:0] obs_d;
  logic       obs_k;
  logic [8:0] ilas_obs [ILAS_N];

  typedef struct {
    int         pos;
    logic [7:0] din;
    logic [7:0] exp_d;
    logic       exp_k;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ILAS octet by its index from the first /R/: positions and ramp count derived arithmetically.
  function automatic void ilas_exp(input int idx, output logic [7:0] o, output logic k);
    int m, p, ramps;
    m = idx / FK;
    p = idx % FK;
    k = 1'b0;
    if (p == 0) begin
      o = 8'h1C; k = 1'b1;
    end else if (p == FK - 1) begin
      o = 8'h7C; k = 1'b1;
    end else if (m == 1 && p == 1) begin
      o = 8'h9C; k = 1'b1;
    end else if (m == 1 && p >= 2 && p <= 15) begin
      o = cfg[p-2];
    end else begin
      ramps = m * (FK - 2) - ((m >= 2) ? 15 : 0) + ((m == 1) ? (p - 16) : (p - 1));
      o = 8'(ramps % 256);
    end
  endfunction

  function automatic void data_exp(input int p, input logic [7:0] d, output logic [7:0] o, output logic k);
    o = d;
    k = 1'b0;
    if (SCR) begin
      if (p == FK - 1 && d == 8'h7C) k = 1'b1;
      else if (p % F == F - 1 && p != FK - 1 && d == 8'hFC) k = 1'b1;
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_low = 0; m_idx = 0; m_sync_r = 1'b0;
  endtask

  // One clock: predict this cycle's decision, advance, then compare the registered outputs.
  task automatic step();
    logic [7:0] eo;
    logic       ek;
    int         p;
    bit         was_data, linked;
    p        = m_cyc % FK;
    was_data = (m_state == 2);
    linked   = (m_state != 0);
    chk("data_en", lane_if.data_en, was_data);
    eo = 8'hBC; ek = 1'b1;
    if (m_state == 0) begin
      if (m_sync_r && p == 0) begin
        ilas_exp(0, eo, ek); m_state = 1; m_idx = 1;
      end
    end else if (m_state == 1) begin
      ilas_exp(m_idx, eo, ek);
      m_idx++;
      if (m_idx == ILAS_N) m_state = 2;
    end else begin
      data_exp(p, lane_if.data_in, eo, ek);
    end
    if (linked) begin
      m_low = m_sync_r ? 0 : m_low + 1;
      if (m_low >= SLM) begin m_state = 0; m_low = 0; end
    end else begin
      m_low = 0;
    end
    m_sync_r = lane_if.sync_n;
    m_cyc++;
    @(posedge clk); #1;
    obs_d = lane_if.data_out;
    obs_k = lane_if.k_out;
    chk("data_out", obs_d, eo);
    chk("k_out", obs_k, ek);
    chk("link_up", lane_if.link_up, was_data);
  endtask

  function automatic logic [7:0] pick_data();
    int r;
    r = $urandom_range(7, 0);
    if (r == 0) return 8'h7C;
    if (r == 1) return 8'hFC;
    return 8'($urandom);
  endfunction

  task automatic step_rand();
    lane_if.data_in = pick_data();
    step();
  endtask

  task automatic run_until_pos(input int target);
    for (int i = 0; i < FK && (m_cyc % FK) != target; i++) step_rand();
  endtask

  // Bounded wait for /R/ on the output; n = steps taken, -1 if it never came.
  task automatic wait_r(output int n);
    n = 0;
    for (int i = 0; i < 2 * FK + 8; i++) begin
      step_rand();
      n++;
      if (obs_k && obs_d == 8'h1C) return;
    end
    n = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", lane_if.data_out, 8'h00);
    chk("rst_k_out", lane_if.k_out, 1'b0);
    chk("rst_data_en", lane_if.data_en, 1'b0);
    chk("rst_link_up", lane_if.link_up, 1'b0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int n, first_bc, low_left;

    for (int j = 0; j < int'(ILAS_CFG_LEN); j++) begin
      cfg[j] = 8'($urandom);
      lane_if.cfg_in[8*j +: 8] = cfg[j];
    end
    lane_if.sync_n  = 1'b0;
    lane_if.data_in = 8'h00;

    vt[0] = '{3,   8'hFC, 8'hFC, 1'b1};
    vt[1] = '{127, 8'h7C, 8'h7C, 1'b1};
    vt[2] = '{3,   8'h7C, 8'h7C, 1'b0};
    vt[3] = '{127, 8'hFC, 8'hFC, 1'b0};
    vt[4] = '{11,  8'hFC, 8'hFC, 1'b1};
    vt[5] = '{12,  8'hFC, 8'hFC, 1'b0};
    vt[6] = '{126, 8'h7C, 8'h7C, 1'b0};
    vt[7] = '{64,  8'hA5, 8'hA5, 1'b0};

    // Reset, then hold SYNC~ low: K28.5 every octet.
    do_reset();
    repeat (300) step_rand();

    // Release at pos 50; /R/ exits with the next pos-0 octet.
    run_until_pos(50);
    lane_if.sync_n = 1'b1;
    wait_r(n);
    chk("r_latency", n, 79);
    ilas_obs[0] = {obs_k, obs_d};
    for (int i = 1; i < ILAS_N; i++) begin
      step_rand();
      ilas_obs[i] = {obs_k, obs_d};
    end
    chk("ilas_last_A", ilas_obs[ILAS_N-1], 9'h17C);
    for (int m = 0; m < ILAS_MF; m++) chk("mf_end_A", ilas_obs[m*FK + FK - 1], 9'h17C);
    chk("mf2_R", ilas_obs[FK], 9'h11C);
    chk("mf2_Q", ilas_obs[FK+1], 9'h19C);
    for (int j = 0; j < int'(ILAS_CFG_LEN); j++) chk("mf2_cfg", ilas_obs[FK+2+j], {1'b0, cfg[j]});
    chk("ramp_start0", ilas_obs[1], 9'h000);
    chk("ramp_start1", ilas_obs[2], 9'h001);
    chk("mf2_ramp", ilas_obs[FK+16], 9'd126);

    // First data octet after ILAS, one cycle of latency.
    lane_if.data_in = 8'h5A;
    step();
    chk("data_latency", obs_d, 8'h5A);
    chk("first_link_up", lane_if.link_up, 1'b1);

    // Replacement vectors.
    for (int i = 0; i < 8; i++) begin
      run_until_pos(vt[i].pos);
      lane_if.data_in = vt[i].din;
      step();
      chk("vec_data", obs_d, vt[i].exp_d);
      chk("vec_k", obs_k, vt[i].exp_k);
    end

    // Three-cycle SYNC~ glitch in DATA is ignored.
    repeat (4) step_rand();
    lane_if.sync_n = 1'b0;
    repeat (3) step_rand();
    lane_if.sync_n = 1'b1;
    repeat (8) step_rand();
    chk("glitch_link_up", lane_if.link_up, 1'b1);

    // Four-cycle low: K28.5 on the output 6 cycles after SYNC~ fell.
    run_until_pos(20);
    lane_if.sync_n = 1'b0;
    first_bc = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) lane_if.sync_n = 1'b1;
      step_rand();
      if (first_bc == 0 && obs_k && obs_d == 8'hBC) first_bc = k;
    end
    chk("resync_latency", first_bc, 6);
    chk("resync_link_down", lane_if.link_up, 1'b0);
    wait_r(n);
    chk("re_ilas_found", n > 0, 1'b1);

    // Reset in the middle of ILAS multiframe 1.
    repeat (FK + 5) step_rand();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midilas_rst_data", lane_if.data_out, 8'h00);
    chk("midilas_rst_k", lane_if.k_out, 1'b0);
    chk("midilas_rst_link", lane_if.link_up, 1'b0);
    reset = 1'b0;
    model_reset();
    repeat (5) step_rand();
    chk("post_rst_cgs", {obs_k, obs_d}, 9'h1BC);

    // Randomised SYNC~ glitches and biased data against the model.
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left == 0 && $urandom_range(40, 0) == 0) low_left = $urandom_range(6, 1);
      lane_if.sync_n = (low_left == 0);
      if (low_left > 0) low_left--;
      step_rand();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
